// File: rtl/l1_icache_pkg.sv
// Shared types and geometry defaults for the direct-mapped L1 instruction cache.
// The optional ICACHE_STATS_EN build adds hit/miss counters in l1_icache only.
package cache_types;

  localparam int DEFAULT_S_OFFSET = 5;
  localparam int DEFAULT_S_INDEX  = 4;
  localparam int LINE_W           = 256;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ALLOC
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Flop-based storage array: asynchronous read, synchronous loaded write.
// Only the valid-bit instance clears on reset; tag and data contents are don't-care.
module icache_array #(
  parameter int WIDTH          = 1,
  parameter int DEPTH          = 16,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (CLEAR_ON_RESET && rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache with zero-latency hits and line fills on miss.
// Define ICACHE_STATS_EN to add the hit_count / miss_count outputs.
module l1_icache
  import cache_types::*;
#(
  parameter int S_OFFSET = DEFAULT_S_OFFSET,
  parameter int S_INDEX  = DEFAULT_S_INDEX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic [31:0]       mem_address,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;
  localparam int NUM_SETS = 1 << S_INDEX;

  icache_state_t state;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [2:0]         req_word;
  logic [S_INDEX-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;

  logic               valid_out;
  logic [TAG_W-1:0]   tag_out;
  logic [LINE_W-1:0]  line_out;

  logic hit;
  logic fill;
  logic unused;

  assign req_tag    = mem_address[31:S_INDEX+S_OFFSET];
  assign req_index  = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign req_word   = mem_address[4:2];
  assign fill_index = pmem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign fill_tag   = pmem_address[31:S_INDEX+S_OFFSET];
  assign unused     = ^mem_address[1:0];

  // Reset wins over a coincident fill so an abandoned request never lands in the arrays.
  assign fill = (state == FETCH) && pmem_resp && !rst;

  icache_array #(.WIDTH(1), .DEPTH(NUM_SETS), .CLEAR_ON_RESET(1'b1)) valid_array (
    .clk   (clk),
    .rst   (rst),
    .load  (fill),
    .waddr (fill_index),
    .wdata (1'b1),
    .raddr (req_index),
    .rdata (valid_out)
  );

  icache_array #(.WIDTH(TAG_W), .DEPTH(NUM_SETS), .CLEAR_ON_RESET(1'b0)) tag_array (
    .clk   (clk),
    .rst   (rst),
    .load  (fill),
    .waddr (fill_index),
    .wdata (fill_tag),
    .raddr (req_index),
    .rdata (tag_out)
  );

  icache_array #(.WIDTH(LINE_W), .DEPTH(NUM_SETS), .CLEAR_ON_RESET(1'b0)) data_array (
    .clk   (clk),
    .rst   (rst),
    .load  (fill),
    .waddr (fill_index),
    .wdata (pmem_rdata),
    .raddr (req_index),
    .rdata (line_out)
  );

  assign hit       = mem_read && valid_out && (tag_out == req_tag);
  assign mem_resp  = (state == IDLE) && hit;
  assign mem_rdata = mem_resp ? line_out[{req_word, 5'b00000} +: 32] : 32'h0;

  // pmem_address doubles as the latched miss address and stays put until the next miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_address <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read && !hit) begin
            state        <= FETCH;
            pmem_read    <= 1'b1;
            pmem_address <= {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            state     <= ALLOC;
            pmem_read <= 1'b0;
          end
        end
        ALLOC: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          pmem_read <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (mem_resp) begin
        hit_count <= hit_count + 32'h1;
      end
      if ((state == IDLE) && mem_read && !hit) begin
        miss_count <= miss_count + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Self-checking bench for l1_icache: directed test-plan scenarios plus randomized traffic
// checked every cycle against a set-level behavioural model. Honors ICACHE_STATS_EN.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic [31:0]  mem_address = 32'h0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  logic         responder_en = 1'b0;
  logic         auto_resp = 1'b0;
  logic         manual_resp = 1'b0;
  logic [255:0] auto_data = '0;
  logic [255:0] manual_data = '0;

  int checks = 0;
  int errors = 0;

  assign pmem_resp  = responder_en ? auto_resp : manual_resp;
  assign pmem_rdata = responder_en ? auto_data : manual_data;

  always #5 clk = ~clk;

  l1_icache dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Immutable instruction memory contents, with two pinned words used by literal checks.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h60000004) return 32'h00100093;
    if (w == 32'h6000001C) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    logic [2:0]   k;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      k = i[2:0];
      l[i*32 +: 32] = word_of({a[31:5], k, 2'b00});
    end
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which line each set holds, plus whether a fill or its bubble is pending.
  logic        mvalid [16];
  logic [26:0] mline  [16];
  bit          busy = 1'b0;
  bit          bubble = 1'b0;
  bit          known = 1'b0;
  logic [26:0] fill_line = '0;
  logic [31:0] exp_hits = 32'h0;
  logic [31:0] exp_misses = 32'h0;

  always @(negedge clk) begin
    logic [3:0] idx;
    bit         h;
    idx = mem_address[8:5];
    h   = !busy && !bubble && mem_read && mvalid[idx] && (mline[idx] == mem_address[31:5]);
    if (known) begin
      checkBit("model_mem_resp", mem_resp, h);
      checkOutput("model_mem_rdata", mem_rdata, h ? word_of(mem_address) : 32'h0);
      checkBit("model_pmem_read", pmem_read, busy);
      if (busy) checkOutput("model_pmem_address", pmem_address, {fill_line, 5'b00000});
`ifdef ICACHE_STATS_EN
      checkOutput("model_hit_count", hit_count, exp_hits);
      checkOutput("model_miss_count", miss_count, exp_misses);
`endif
    end
    if (rst) begin
      busy       = 1'b0;
      bubble     = 1'b0;
      exp_hits   = 32'h0;
      exp_misses = 32'h0;
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      known = 1'b1;
    end else begin
      if (h) exp_hits = exp_hits + 32'h1;
      if (busy) begin
        if (pmem_resp) begin
          mvalid[fill_line[3:0]] = 1'b1;
          mline[fill_line[3:0]]  = fill_line;
          busy   = 1'b0;
          bubble = 1'b1;
        end
      end else if (bubble) begin
        bubble = 1'b0;
      end else if (mem_read && !h) begin
        busy       = 1'b1;
        fill_line  = mem_address[31:5];
        exp_misses = exp_misses + 32'h1;
      end
    end
  end

  // Random-latency memory that also throws stray responses when no fill is outstanding.
  initial begin
    int wait_cnt;
    wait_cnt = $urandom_range(0, 4);
    forever begin
      @(posedge clk);
      #1;
      auto_resp = 1'b0;
      if (pmem_read) begin
        if (wait_cnt == 0) begin
          auto_resp = 1'b1;
          auto_data = line_of(pmem_address);
          wait_cnt  = $urandom_range(0, 4);
        end else begin
          wait_cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        auto_resp = 1'b1;
        auto_data = {8{$urandom}};
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rd, input logic [31:0] a);
    @(posedge clk);
    #1;
    mem_read    = rd;
    mem_address = a;
  endtask

  task automatic observe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    rst = 1'b0;
  endtask

  // Call right after the miss cycle: checks the request, answers after lat extra cycles, checks the hit.
  task automatic finish_fill(input logic [31:0] a, input int lat, input string name);
    applyStimulus(1'b1, a);
    observe();
    checkBit({name, "_pmem_read"}, pmem_read, 1'b1);
    checkOutput({name, "_pmem_address"}, pmem_address, {a[31:5], 5'b00000});
    repeat (lat) applyStimulus(1'b1, a);
    applyStimulus(1'b1, a);
    manual_resp = 1'b1;
    manual_data = line_of(a);
    applyStimulus(1'b1, a);
    manual_resp = 1'b0;
    observe();
    checkBit({name, "_alloc_resp"}, mem_resp, 1'b0);
    applyStimulus(1'b1, a);
    observe();
    checkBit({name, "_hit_resp"}, mem_resp, 1'b1);
    checkOutput({name, "_hit_rdata"}, mem_rdata, word_of(a));
  endtask

  task automatic miss_fill(input logic [31:0] a, input int lat, input string name);
    applyStimulus(1'b1, a);
    observe();
    checkBit({name, "_miss_resp"}, mem_resp, 1'b0);
    finish_fill(a, lat, name);
  endtask

  initial begin
    logic [31:0] addr;
    $display("[TB] start");
    do_reset();
    observe();
    checkBit("reset_mem_resp", mem_resp, 1'b0);
    checkBit("reset_pmem_read", pmem_read, 1'b0);
    checkOutput("reset_pmem_address", pmem_address, 32'h0);
    checkOutput("reset_mem_rdata", mem_rdata, 32'h0);

    // Cold miss: memory answers on the fourth pmem_read cycle.
    miss_fill(32'h60000004, 2, "cold");
    checkOutput("cold_rdata_literal", mem_rdata, 32'h00100093);
`ifdef ICACHE_STATS_EN
    checkOutput("cold_miss_count", miss_count, 32'd1);
`endif

    applyStimulus(1'b1, 32'h6000001C);
    observe();
    checkBit("same_line_resp", mem_resp, 1'b1);
    checkOutput("same_line_rdata", mem_rdata, 32'hDEADBEEF);
    checkBit("same_line_pmem_read", pmem_read, 1'b0);

    miss_fill(32'h60000200, 1, "evict");
    miss_fill(32'h60000004, 0, "refetch");
    checkOutput("refetch_rdata_literal", mem_rdata, 32'h00100093);

    // Address moves on while the first fill is outstanding.
    applyStimulus(1'b1, 32'h60000040);
    observe();
    checkBit("midfill_miss_resp", mem_resp, 1'b0);
    applyStimulus(1'b1, 32'h60000040);
    observe();
    checkOutput("midfill_paddr_first", pmem_address, 32'h60000040);
    applyStimulus(1'b1, 32'h60000080);
    observe();
    checkOutput("midfill_paddr_held", pmem_address, 32'h60000040);
    checkBit("midfill_fetch_resp", mem_resp, 1'b0);
    applyStimulus(1'b1, 32'h60000080);
    manual_resp = 1'b1;
    manual_data = line_of(32'h60000040);
    applyStimulus(1'b1, 32'h60000080);
    manual_resp = 1'b0;
    observe();
    checkBit("midfill_alloc_resp", mem_resp, 1'b0);
    applyStimulus(1'b1, 32'h60000080);
    observe();
    checkBit("midfill_second_miss", mem_resp, 1'b0);
    finish_fill(32'h60000080, 1, "midfill_second");
    checkOutput("midfill_second_paddr_literal", pmem_address, 32'h60000080);
    applyStimulus(1'b1, 32'h60000044);
    observe();
    checkBit("midfill_first_line_hit", mem_resp, 1'b1);

    // Reset while fetching, with the stale response arriving just afterwards.
    applyStimulus(1'b1, 32'h600000C0);
    observe();
    checkBit("rstfetch_miss_resp", mem_resp, 1'b0);
    applyStimulus(1'b1, 32'h600000C0);
    observe();
    checkBit("rstfetch_pmem_read_on", pmem_read, 1'b1);
    applyStimulus(1'b0, 32'h600000C0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h600000C0);
    rst = 1'b0;
    manual_resp = 1'b1;
    manual_data = line_of(32'h600000C0);
    observe();
    checkBit("rstfetch_pmem_read_off", pmem_read, 1'b0);
    applyStimulus(1'b0, 32'h600000C0);
    manual_resp = 1'b0;
    observe();
    checkBit("rstfetch_stale_ignored", pmem_read, 1'b0);
    miss_fill(32'h600000C0, 0, "rstfetch_refill");
    miss_fill(32'h60000004, 0, "post_reset_cold");

    // Two misses then ten hits: twelve response cycles in total.
    do_reset();
    miss_fill(32'h60000300, 0, "stats_a");
    miss_fill(32'h60000420, 1, "stats_b");
    for (int i = 0; i < 10; i++) begin
      addr = (i % 2 == 0) ? 32'h60000300 : 32'h60000420;
      applyStimulus(1'b1, addr + 32'(4 * (i % 8)));
    end
    applyStimulus(1'b0, 32'h0);
    observe();
    checkBit("stats_idle_resp", mem_resp, 1'b0);
`ifdef ICACHE_STATS_EN
    checkOutput("stats_hit_count", hit_count, 32'd12);
    checkOutput("stats_miss_count", miss_count, 32'd2);
`endif

    // Randomized traffic over three tags and all sets, with occasional resets.
    responder_en = 1'b1;
    addr = 32'h60000000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        addr = 32'h60000000 + (32'($urandom_range(0, 2)) << 9) + (32'($urandom_range(0, 15)) << 5)
             + 32'($urandom_range(0, 31));
      end
      applyStimulus($urandom_range(0, 3) != 0, addr);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    repeat (8) applyStimulus(1'b0, 32'h0);
    observe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
